// File: rtl/mc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mc_controller                                                |
// | Description : Moore sequencer for the multicycle MIPS-style core. Decodes  |
// |               the latched instruction and drives all datapath selects and  |
// |               write enables, one state per cycle.                          |
// | Options     : define MC_BLT_EN to decode op 000101 as blt (branch when     |
// |               negdiff); otherwise that opcode is illegal.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       negdiff,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic [1:0] alusrca,
    output logic [2:0] alusrcb,
    output logic [3:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal,
    output logic       instret
);

    localparam logic [5:0] C_OP_R    = 6'b000000;
    localparam logic [5:0] C_OP_J    = 6'b000010;
    localparam logic [5:0] C_OP_BEQ  = 6'b000100;
    localparam logic [5:0] C_OP_BLT  = 6'b000101;
    localparam logic [5:0] C_OP_ADDI = 6'b001000;
    localparam logic [5:0] C_OP_LUI  = 6'b001111;
    localparam logic [5:0] C_OP_LI   = 6'b001101;
    localparam logic [5:0] C_OP_LW   = 6'b100011;
    localparam logic [5:0] C_OP_SW   = 6'b101011;

    localparam logic [3:0] C_ALU_AND = 4'b0000;
    localparam logic [3:0] C_ALU_OR  = 4'b0001;
    localparam logic [3:0] C_ALU_ADD = 4'b0010;
    localparam logic [3:0] C_ALU_SUB = 4'b0110;
    localparam logic [3:0] C_ALU_SLT = 4'b0111;
    localparam logic [3:0] C_ALU_SLL = 4'b1000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_UPEX   = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_taken;
    logic [3:0] w_funct_alu;
    logic       w_funct_ok;

`ifdef MC_BLT_EN
    assign w_taken = (op == C_OP_BLT) ? negdiff : zero;
`else
    logic w_unused_negdiff;
    assign w_unused_negdiff = negdiff;
    assign w_taken          = zero;
`endif

    // PC loads on unconditional writes or on a taken branch (same cycle).
    assign pcen = w_pcwrite | (w_branch & w_taken);

    // State register; reset abandons any instruction in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // R-type function field to ALU operation.
    always_comb begin
        w_funct_alu = C_ALU_AND;
        w_funct_ok  = 1'b1;
        case (funct)
            6'b100000: w_funct_alu = C_ALU_ADD;
            6'b100010: w_funct_alu = C_ALU_SUB;
            6'b100100: w_funct_alu = C_ALU_AND;
            6'b100101: w_funct_alu = C_ALU_OR;
            6'b101010: w_funct_alu = C_ALU_SLT;
            6'b000000: w_funct_alu = C_ALU_SLL;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    // Next-state and per-state output decode.
    always_comb begin
        w_next     = S_FETCH;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 2'd0;
        alusrcb    = 3'd0;
        alucontrol = C_ALU_AND;
        pcsrc      = 2'd0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        illegal    = 1'b0;
        instret    = 1'b0;
        case (r_state)
            S_FETCH: begin
                irwrite    = 1'b1;
                alusrcb    = 3'd1;
                alucontrol = C_ALU_ADD;
                w_pcwrite  = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                alusrcb    = 3'd3;
                alucontrol = C_ALU_ADD;
                case (op)
                    C_OP_LW, C_OP_SW: w_next = S_MEMADR;
                    C_OP_R:           w_next = S_EXEC;
                    C_OP_BEQ:         w_next = S_BRANCH;
`ifdef MC_BLT_EN
                    C_OP_BLT:         w_next = S_BRANCH;
`endif
                    C_OP_ADDI:        w_next = S_IMMEX;
                    C_OP_LUI, C_OP_LI: w_next = S_UPEX;
                    C_OP_J:           w_next = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 2'd1;
                alusrcb    = 3'd2;
                alucontrol = C_ALU_ADD;
                w_next     = (op == C_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                instret  = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                instret  = 1'b1;
            end
            S_EXEC: begin
                alusrca    = 2'd1;
                alucontrol = w_funct_alu;
                illegal    = ~w_funct_ok;
                w_next     = w_funct_ok ? S_ALUWB : S_FETCH;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                instret  = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 2'd1;
                alucontrol = C_ALU_SUB;
                pcsrc      = 2'd1;
                w_branch   = 1'b1;
                instret    = 1'b1;
            end
            S_IMMEX: begin
                alusrca    = 2'd1;
                alusrcb    = 3'd2;
                alucontrol = C_ALU_ADD;
                w_next     = S_IMMWB;
            end
            S_UPEX: begin
                alusrca    = 2'd2;
                alusrcb    = (op == C_OP_LUI) ? 3'd4 : 3'd5;
                alucontrol = C_ALU_ADD;
                w_next     = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite = 1'b1;
                instret  = 1'b1;
            end
            S_JUMP: begin
                pcsrc     = 2'd2;
                w_pcwrite = 1'b1;
                instret   = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mc_controller                                             |
// | Description : Self-checking bench for mc_controller. Expected outputs come |
// |               from per-instruction step lists built from the ISA rules.    |
// | Options     : honours MC_BLT_EN the same way as the design.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       negdiff = 1'b0;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic [1:0] alusrca;
    logic [2:0] alusrcb;
    logic [3:0] alucontrol;
    logic [1:0] pcsrc;
    logic       pcen, illegal, instret;

    int n_checks = 0;
    int n_fail   = 0;
    bit rnd_flags = 1'b1;
    bit fix_zero  = 1'b0;
    bit fix_neg   = 1'b0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct),
        .zero(zero), .negdiff(negdiff),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
        .pcsrc(pcsrc), .pcen(pcen), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Packs all outputs as {iord,memwrite,irwrite,regdst,memtoreg,regwrite,
    // alusrca,alusrcb,alucontrol,pcsrc,pcen,illegal,instret}.
    function automatic logic [19:0] ev(
        input logic io, input logic mw, input logic ir, input logic rd,
        input logic mr, input logic rw, input logic [1:0] sa, input logic [2:0] sb,
        input logic [3:0] alu, input logic [1:0] ps, input logic pe,
        input logic il, input logic rt);
        return {io, mw, ir, rd, mr, rw, sa, sb, alu, ps, pe, il, rt};
    endfunction

    function automatic logic [19:0] obs();
        return {iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal, instret};
    endfunction

    task automatic check(input logic [19:0] exp, input string tag);
        logic [19:0] o;
        o = obs();
        n_checks++;
        assert (o === exp) else begin
            n_fail++;
            $error("FAIL %s op=%b funct=%b observed=%h expected=%h", tag, op, funct, o, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (rnd_flags) begin
            zero    = 1'($urandom);
            negdiff = 1'($urandom);
        end else begin
            zero    = fix_zero;
            negdiff = fix_neg;
        end
        #1;
    endtask

    function automatic bit op_legal(input logic [5:0] o);
        case (o)
            6'b000000, 6'b000010, 6'b000100, 6'b001000,
            6'b001111, 6'b001101, 6'b100011, 6'b101011: return 1'b1;
`ifdef MC_BLT_EN
            6'b000101: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Reference sequence for one instruction; entered in its FETCH cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit stop_in_memwr);
        bit         ok;
        logic [3:0] a;
        op    = o;
        funct = f;
        zero    = rnd_flags ? 1'($urandom) : fix_zero;
        negdiff = rnd_flags ? 1'($urandom) : fix_neg;
        #1;
        check(ev(0,0,1,0,0,0,2'd0,3'd1,4'b0010,2'd0,1,0,0), "fetch");
        next_cycle();
        check(ev(0,0,0,0,0,0,2'd0,3'd3,4'b0010,2'd0,0,!op_legal(o),0), "decode");
        if (!op_legal(o)) begin
            next_cycle();
            return;
        end
        next_cycle();
        case (o)
            6'b100011, 6'b101011: begin
                check(ev(0,0,0,0,0,0,2'd1,3'd2,4'b0010,2'd0,0,0,0), "memadr");
                next_cycle();
                if (o == 6'b100011) begin
                    check(ev(1,0,0,0,0,0,2'd0,3'd0,4'b0000,2'd0,0,0,0), "memrd");
                    next_cycle();
                    check(ev(0,0,0,0,1,1,2'd0,3'd0,4'b0000,2'd0,0,0,1), "memwb");
                end else begin
                    check(ev(1,1,0,0,0,0,2'd0,3'd0,4'b0000,2'd0,0,0,1), "memwr");
                    if (stop_in_memwr) return;
                end
            end
            6'b000000: begin
                ok = 1'b1;
                a  = 4'b0000;
                case (f)
                    6'b100000: a = 4'b0010;
                    6'b100010: a = 4'b0110;
                    6'b100100: a = 4'b0000;
                    6'b100101: a = 4'b0001;
                    6'b101010: a = 4'b0111;
                    6'b000000: a = 4'b1000;
                    default:   ok = 1'b0;
                endcase
                check(ev(0,0,0,0,0,0,2'd1,3'd0,a,2'd0,0,!ok,0), "exec");
                if (ok) begin
                    next_cycle();
                    check(ev(0,0,0,1,0,1,2'd0,3'd0,4'b0000,2'd0,0,0,1), "aluwb");
                end
            end
            6'b000100, 6'b000101:
                check(ev(0,0,0,0,0,0,2'd1,3'd0,4'b0110,2'd1,
                         (o == 6'b000100) ? zero : negdiff,0,1), "branch");
            6'b001000, 6'b001111, 6'b001101: begin
                if (o == 6'b001000)
                    check(ev(0,0,0,0,0,0,2'd1,3'd2,4'b0010,2'd0,0,0,0), "immex");
                else
                    check(ev(0,0,0,0,0,0,2'd2,(o == 6'b001111) ? 3'd4 : 3'd5,
                             4'b0010,2'd0,0,0,0), "upex");
                next_cycle();
                check(ev(0,0,0,0,0,1,2'd0,3'd0,4'b0000,2'd0,0,0,1), "immwb");
            end
            default:
                check(ev(0,0,0,0,0,0,2'd0,3'd0,4'b0000,2'd2,1,0,1), "jump");
        endcase
        next_cycle();
    endtask

    localparam logic [19:0] C_FETCH_VEC = 20'({1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,
                                               2'd0,3'd1,4'b0010,2'd0,1'b1,1'b0,1'b0});

    logic [5:0] ops [0:9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                              6'b001000, 6'b001111, 6'b001101, 6'b000010, 6'b111111};
    logic [5:0] fns [0:6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b101010, 6'b000000, 6'b010101};

    initial begin
        // Reset held for three cycles.
        repeat (3) begin
            @(posedge clk);
            #1;
            check(C_FETCH_VEC, "reset");
        end
        reset = 1'b0;

        // Directed instructions with fixed flags.
        rnd_flags = 1'b0;
        run_instr(6'b100011, 6'b000000, 1'b0);
        run_instr(6'b000000, 6'b100010, 1'b0);
        run_instr(6'b000000, 6'b111111, 1'b0);
        fix_zero = 1'b1;
        run_instr(6'b000100, 6'b000000, 1'b0);
        fix_zero = 1'b0;
        run_instr(6'b000100, 6'b000000, 1'b0);
        fix_neg = 1'b1;
        run_instr(6'b000101, 6'b000000, 1'b0);
        fix_neg = 1'b0;
        run_instr(6'b001111, 6'b000000, 1'b0);
        run_instr(6'b001101, 6'b000000, 1'b0);
        run_instr(6'b000010, 6'b000000, 1'b0);

        // Reset asserted while a store is writing memory.
        run_instr(6'b101011, 6'b000000, 1'b1);
        #1 reset = 1'b1;
        #1 check(C_FETCH_VEC, "reset_in_memwr");
        @(posedge clk);
        #1 check(C_FETCH_VEC, "reset_hold");
        reset = 1'b0;
        run_instr(6'b001000, 6'b000000, 1'b0);

        // Random instruction stream.
        rnd_flags = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [5:0] o;
            logic [5:0] f;
            o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            run_instr(o, f, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
